// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache and D-cache.
// Each owner keeps the port for its whole burst, and its in-flight reads drain before the owner changes.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int MAX_OUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_data_valid,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid,
    output logic        arb_err
);
    localparam int CW = $clog2(MAX_OUT + 1);

    if (MEM_LAT < 1 || MAX_OUT < 1) begin : g_param_check
        $error("mem_arbiter: MEM_LAT and MAX_OUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_t;

    state_t        state;
    logic          owner_d;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_next;
    logic          owner_req;
    logic          full;
    logic          empty;
    logic          ret;
    logic          d_wins;

    always_comb begin
        i_grant      = state == OWN_I;
        d_grant      = state == OWN_D;
        owner_req    = i_grant ? i_req : d_grant & d_req;
        full         = outstanding == CW'(MAX_OUT);
        empty        = outstanding == '0;
        mem_wr       = d_grant & d_wr;
        // A read issued at the outstanding limit is suppressed; writes never count.
        mem_enable   = owner_req & (mem_wr | ~full);
        mem_addr     = i_grant ? i_addr : d_grant ? d_addr : 16'h0;
        mem_wdata    = d_grant ? d_wdata : 16'h0;
        ret          = mem_data_valid & ~empty;
        i_data_valid = ret & ~owner_d;
        d_data_valid = ret & owner_d;
        out_next     = outstanding + CW'(mem_enable & ~mem_wr) - CW'(ret);
        // owner_d doubles as last_owner, so a tie goes to the cache that did not own last.
        d_wins       = d_req & (~i_req | ~owner_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            outstanding <= '0;
            arb_err     <= 1'b0;
        end else begin
            outstanding <= out_next;
            if ((owner_req & ~mem_wr & full) | (mem_data_valid & empty))
                arb_err <= 1'b1;
            if (state == IDLE && (i_req | d_req)) begin
                state   <= d_wins ? OWN_D : OWN_I;
                owner_d <= d_wins;
            end else if ((i_grant | d_grant) & ~owner_req)
                state <= out_next == '0 ? IDLE : DRAIN;
            else if (state == DRAIN && out_next == '0)
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, multi-cycle corner sequences and random traffic
// checked against a transaction-level ownership/credit model of the arbiter.
module tb_mem_arbiter;
    localparam int MEM_LAT = 4;
    localparam int MAX_OUT = 8;

    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_wr, mem_data_valid;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, i_data_valid, d_grant, d_data_valid;
    logic        mem_enable, mem_wr, arb_err;
    logic [15:0] mem_addr, mem_wdata;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data_valid(d_data_valid),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r, ir, dr, dw, mv;
        logic [15:0] da, dd;
        logic [38:0] exp;
    } vec_t;

    int checks = 0, errors = 0, cyc = 0;
    int cnt_ig, cnt_en, cnt_idv, cnt_ddv, m_reads;
    // Reference model: holder (0 none, 1 I, 2 D), last holder, read credits in flight.
    int m_own, m_last, m_out;
    bit m_drain, m_err;
    bit auto_mem, stray, drop;
    bit [31:0] sched;
    vec_t tv[27];

    function automatic logic [38:0] pack(bit gi, gd, en, wr, logic [15:0] ma, mw,
                                         bit idv, ddv, er);
        return {gi, gd, en, wr, ma, mw, idv, ddv, er};
    endfunction

    function automatic vec_t row(bit r, ir, dr, dw, mv, logic [15:0] da, dd,
                                 bit gi, gd, en, wr, logic [15:0] ma, mw, bit idv, ddv, er);
        vec_t v;
        v.r = r; v.ir = ir; v.dr = dr; v.dw = dw; v.mv = mv; v.da = da; v.dd = dd;
        v.exp = pack(gi, gd, en, wr, ma, mw, idv, ddv, er);
        return v;
    endfunction

    function automatic logic [38:0] dut_out();
        return {i_grant, d_grant, mem_enable, mem_wr, mem_addr, mem_wdata,
                i_data_valid, d_data_valid, arb_err};
    endfunction

    function automatic bit holder_req();
        return m_own == 1 ? i_req : m_own == 2 ? d_req : 1'b0;
    endfunction

    function automatic logic [38:0] model_out();
        bit wr, en, dv;
        int tgt;
        wr  = m_own == 2 && d_wr;
        en  = holder_req() && (wr || m_out < MAX_OUT);
        dv  = mem_data_valid && m_out > 0;
        tgt = m_own != 0 ? m_own : m_last;
        return pack(m_own == 1, m_own == 2, en, wr,
                    m_own == 1 ? i_addr : m_own == 2 ? d_addr : 16'h0,
                    m_own == 2 ? d_wdata : 16'h0, dv && tgt == 1, dv && tgt == 2, m_err);
    endfunction

    task automatic model_reset();
        m_own = 0; m_last = 1; m_out = 0; m_drain = 0; m_err = 0; sched = '0;
    endtask

    task automatic chk(input string name, input logic [38:0] got, input logic [38:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic clr_counts();
        cnt_ig = 0; cnt_en = 0; cnt_idv = 0; cnt_ddv = 0; m_reads = 0;
    endtask

    task automatic step(input bit has_tab, input logic [38:0] tab);
        logic [38:0] exp;
        bit rd, dv;
        if (auto_mem) mem_data_valid = (sched[0] & ~drop) | stray;
        exp = model_out();
        #1;
        chk("model", dut_out(), exp);
        if (has_tab) chk("table", dut_out(), tab);
        cnt_ig  += int'(i_grant);
        cnt_en  += int'(mem_enable);
        cnt_idv += int'(i_data_valid);
        cnt_ddv += int'(d_data_valid);
        rd = exp[36] & ~exp[35];
        m_reads += int'(rd);
        sched = sched >> 1;
        if (rst) model_reset();
        else begin
            dv = mem_data_valid && m_out > 0;
            if ((holder_req() && !exp[35] && m_out == MAX_OUT) || (mem_data_valid && m_out == 0))
                m_err = 1;
            if (rd) sched[MEM_LAT-1] = 1'b1;
            m_out = m_out + int'(rd) - int'(dv);
            if (m_own != 0) begin
                if (!holder_req()) begin
                    m_last = m_own; m_own = 0; m_drain = m_out != 0;
                end
            end else if (m_drain) m_drain = m_out != 0;
            else if (i_req || d_req)
                m_own = (i_req && d_req) ? (m_last == 1 ? 2 : 1) : (i_req ? 1 : 2);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; d_wr = 0; mem_data_valid = 0; stray = 0; drop = 0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1; step(0, '0); rst = 0;
    endtask

    initial begin
        rst = 1; auto_mem = 0; idle_inputs(); model_reset(); clr_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);

        tv[0]  = row(1,0,0,0,0,'h0,'h0,       0,0,0,0,'h0,'h0,0,0,0);
        tv[1]  = row(0,1,1,0,0,'h2222,'h3333, 0,0,0,0,'h0,'h0,0,0,0);
        tv[2]  = row(0,1,1,0,0,'h2222,'h3333, 0,1,1,0,'h2222,'h3333,0,0,0);
        tv[3]  = tv[2];
        tv[4]  = tv[2];
        tv[5]  = tv[2];
        tv[6]  = row(0,1,0,0,0,'h2222,'h3333, 0,1,0,0,'h2222,'h3333,0,0,0);
        tv[7]  = row(0,1,0,0,1,'h2222,'h3333, 0,0,0,0,'h0,'h0,0,1,0);
        tv[8]  = tv[7];
        tv[9]  = tv[7];
        tv[10] = tv[7];
        tv[11] = row(0,1,0,0,0,'h2222,'h3333, 0,0,0,0,'h0,'h0,0,0,0);
        tv[12] = row(0,1,1,0,0,'h2222,'h3333, 1,0,1,0,'h1111,'h0,0,0,0);
        tv[13] = row(0,0,1,0,1,'h2222,'h3333, 1,0,0,0,'h1111,'h0,1,0,0);
        tv[14] = row(0,1,1,0,0,'h2222,'h3333, 0,0,0,0,'h0,'h0,0,0,0);
        tv[15] = row(0,1,1,1,0,'h00F0,'hBEEF, 0,1,1,1,'h00F0,'hBEEF,0,0,0);
        tv[16] = row(0,1,0,1,0,'h00F0,'hBEEF, 0,1,0,1,'h00F0,'hBEEF,0,0,0);
        tv[17] = row(0,1,0,0,0,'h0,'h0,       0,0,0,0,'h0,'h0,0,0,0);
        tv[18] = row(0,1,1,0,0,'h2222,'h3333, 1,0,1,0,'h1111,'h0,0,0,0);
        tv[19] = row(0,0,1,0,0,'h2222,'h3333, 1,0,0,0,'h1111,'h0,0,0,0);
        tv[20] = row(0,0,1,0,1,'h2222,'h3333, 0,0,0,0,'h0,'h0,1,0,0);
        tv[21] = row(0,0,1,0,0,'h2222,'h3333, 0,0,0,0,'h0,'h0,0,0,0);
        tv[22] = row(0,0,0,0,0,'h2222,'h3333, 0,1,0,0,'h2222,'h3333,0,0,0);
        tv[23] = row(0,0,0,0,1,'h0,'h0,       0,0,0,0,'h0,'h0,0,0,0);
        tv[24] = row(0,0,0,0,0,'h0,'h0,       0,0,0,0,'h0,'h0,0,0,1);
        tv[25] = row(1,0,0,0,0,'h0,'h0,       0,0,0,0,'h0,'h0,0,0,1);
        tv[26] = row(0,0,0,0,0,'h0,'h0,       0,0,0,0,'h0,'h0,0,0,0);
        i_addr = 16'h1111;
        for (int t = 0; t < 27; t++) begin
            rst = tv[t].r; i_req = tv[t].ir; d_req = tv[t].dr; d_wr = tv[t].dw;
            mem_data_valid = tv[t].mv; d_addr = tv[t].da; d_wdata = tv[t].dd;
            step(1, tv[t].exp);
        end

        // Long I-cache burst against a fixed-latency memory.
        idle_inputs(); do_reset(); auto_mem = 1; clr_counts();
        for (int k = 0; k < 12; k++) begin
            i_req = 1; i_addr = 16'h1230 + 16'(k); step(0, '0);
        end
        i_req = 0;
        repeat (10) step(0, '0);
        chk("burst_grant_cycles", 39'(cnt_ig), 39'd12);
        chk("burst_returns", 39'(cnt_idv), 39'(m_reads));
        chk("burst_reads", 39'(m_reads), 39'd11);

        // Nine reads with no returns: the ninth must be suppressed and flagged.
        idle_inputs(); auto_mem = 0; do_reset(); clr_counts();
        d_req = 1; d_addr = 16'h4000;
        repeat (10) step(0, '0);
        d_req = 0; step(0, '0);
        chk("overflow_enables", 39'(cnt_en), 39'd8);
        chk("overflow_err", 39'(arb_err), 39'd1);
        mem_data_valid = 1;
        repeat (8) step(0, '0);
        mem_data_valid = 0;
        repeat (2) step(0, '0);
        chk("overflow_drained", 39'(cnt_ddv), 39'd8);
        chk("err_sticky", 39'(arb_err), 39'd1);

        // Reset in the middle of an I burst.
        idle_inputs(); do_reset(); auto_mem = 1;
        i_req = 1; i_addr = 16'h5000;
        repeat (5) step(0, '0);
        rst = 1; step(0, '0); rst = 0;
        chk("reset_mid_burst", dut_out(), '0);
        repeat (3) step(0, '0);

        // Random traffic against the model.
        idle_inputs(); do_reset(); auto_mem = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 499) == 0;
            if ($urandom_range(0, 7) == 0) i_req = ~i_req;
            if ($urandom_range(0, 5) == 0) begin
                d_req = ~d_req; d_wr = $urandom_range(0, 3) == 0;
            end
            i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            stray = $urandom_range(0, 59) == 0;
            drop = $urandom_range(0, 15) == 0;
            step(0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
